selector_sequencer: RTL and testbench

- Sequencer/controller that drives a 2-bit-op selector datapath (ops: 00 pass a, 01 pass b, 10 a&b, 11 a|b; NQ = ~Q) through a programmed list of up to STEPS operations, one per clock.
- Latches an op list and per-step operand bits on a start handshake.
- Runs one op per cycle and collects each Q/NQ into result vectors, then pulses done.
- Sits between a host/testbench controller and the embedded selector function. Replaces hand-driven sel sequencing.

---
 rtl/selector_sequencer.sv | 161 ++++++++++++++++
 tb/tb_selector_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/selector_sequencer.sv
// Sequencer that runs a latched list of 2-bit selector ops, one per clock, and collects Q/NQ per step.
// Optional SELSEQ_PARITY_EN adds a registered parity output over the collected result.
module selector_cell (
    input  logic [1:0] sel,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       nq
);
    always_comb begin
        q = 1'b0;
        unique case (sel)
            2'b00: q = a;
            2'b01: q = b;
            2'b10: q = a & b;
            2'b11: q = a | b;
        endcase
    end

    assign nq = ~q;
endmodule

module selector_sequencer #(
    parameter int STEPS = 4,
    parameter int CW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CW-1:0]      len,
    input  logic [2*STEPS-1:0] op_seq,
    input  logic [STEPS-1:0]   a_vec,
    input  logic [STEPS-1:0]   b_vec,
    output logic               busy,
    output logic               done,
    output logic [1:0]         sel_o,
    output logic               q_o,
    output logic [STEPS-1:0]   result,
    output logic [STEPS-1:0]   nresult
`ifdef SELSEQ_PARITY_EN
    ,
    output logic               parity
`endif
);
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] STEPS_C = CW'(STEPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state;
    logic [SW-1:0]          step;
    logic [SW-1:0]          last;
    logic [STEPS-1:0][1:0]  op_q;
    logic [STEPS-1:0]       a_q;
    logic [STEPS-1:0]       b_q;
    logic [STEPS-1:0]       q_all;
    logic [STEPS-1:0]       nq_all;
    logic [STEPS-1:0]       res_nxt;
    logic [STEPS-1:0]       nres_nxt;
    logic [CW-1:0]          len_eff;
    logic                   run;
    logic [1:0]             sel_cur;
    logic                   q_cur;

    // One selector per step slot; the active slot is picked by the step index.
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_cell
        selector_cell u_cell (
            .sel (op_q[gi]),
            .a   (a_q[gi]),
            .b   (b_q[gi]),
            .q   (q_all[gi]),
            .nq  (nq_all[gi])
        );
    end

    always_comb begin
        len_eff = len;
        if (len == '0)
            len_eff = CW'(1);
        else if (len > STEPS_C)
            len_eff = STEPS_C;
    end

    assign run     = (state == S_RUN);
    assign sel_cur = op_q[step];
    assign q_cur   = q_all[step];

    assign busy  = run;
    assign done  = (state == S_DONE);
    assign sel_o = run ? sel_cur : 2'b00;
    assign q_o   = run & q_cur;

    always_comb begin
        res_nxt        = result;
        nres_nxt       = nresult;
        res_nxt[step]  = q_cur;
        nres_nxt[step] = nq_all[step];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= '0;
            last    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            nresult <= '0;
`ifdef SELSEQ_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    // start takes priority over abort here; abort only matters in RUN
                    if (start) begin
                        op_q    <= op_seq;
                        a_q     <= a_vec;
                        b_q     <= b_vec;
                        last    <= SW'(len_eff - CW'(1));
                        step    <= '0;
                        result  <= '0;
                        nresult <= '0;
`ifdef SELSEQ_PARITY_EN
                        parity  <= 1'b0;
`endif
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // the step in flight is dropped; already written bits stay
                        state <= S_IDLE;
                        step  <= '0;
                    end else begin
                        result  <= res_nxt;
                        nresult <= nres_nxt;
                        if (step == last) begin
                            state <= S_DONE;
                            step  <= '0;
`ifdef SELSEQ_PARITY_EN
                            parity <= ^res_nxt;
`endif
                        end else begin
                            step <= step + SW'(1);
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    step  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_selector_sequencer.sv
// Directed bench for selector_sequencer (STEPS=4): sequencing, clamping, abort, retrigger and reset.
module tb_selector_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] len = '0;
    logic [7:0] op_seq = '0;
    logic [3:0] a_vec = '0;
    logic [3:0] b_vec = '0;
    logic       busy, done, q_o;
    logic [1:0] sel_o;
    logic [3:0] result, nresult;
`ifdef SELSEQ_PARITY_EN
    logic       parity;
`endif
    int checks = 0;
    int errors = 0;

    selector_sequencer #(.STEPS(4), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .len     (len),
        .op_seq  (op_seq),
        .a_vec   (a_vec),
        .b_vec   (b_vec),
        .busy    (busy),
        .done    (done),
        .sel_o   (sel_o),
        .q_o     (q_o),
        .result  (result),
        .nresult (nresult)
`ifdef SELSEQ_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_step(input string tag, input logic [1:0] s, input logic q);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sel"}, 32'(sel_o), 32'(s));
        chk({tag, "_q"}, 32'(q_o), 32'(q));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sel"}, 32'(sel_o), 32'd0);
        chk({tag, "_q"}, 32'(q_o), 32'd0);
    endtask

    task automatic go(input logic [3:0] l, input logic [7:0] o, input logic [3:0] a, input logic [3:0] b);
        len = l; op_seq = o; a_vec = a; b_vec = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        rst = 1'b0;
        chk_quiet("rst");
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_nres", 32'(nresult), 32'd0);
`ifdef SELSEQ_PARITY_EN
        chk("rst_par", 32'(parity), 32'd0);
`endif
        tick();
        chk_quiet("idle");

        // full sequence: q = 1,1,0,0
        go(4'd4, 8'b11100100, 4'b0101, 4'b0011);
        chk_step("full0", 2'b00, 1'b1);
        tick(); chk_step("full1", 2'b01, 1'b1);
        tick(); chk_step("full2", 2'b10, 1'b0);
        tick(); chk_step("full3", 2'b11, 1'b0);
        tick();
        chk("full_done", 32'(done), 32'd1);
        chk_quiet("full_dn");
        chk("full_res", 32'(result), 32'h3);
        chk("full_nres", 32'(nresult), 32'hC);
`ifdef SELSEQ_PARITY_EN
        chk("full_par", 32'(parity), 32'd0);
`endif
        tick();
        chk("full_done_off", 32'(done), 32'd0);
        chk("full_hold", 32'(result), 32'h3);

        // short sequence
        go(4'd2, 8'b00001011, 4'b0001, 4'b0001);
        chk("short_clr", 32'(result), 32'd0);
        chk_step("short0", 2'b11, 1'b1);
        tick(); chk_step("short1", 2'b10, 1'b0);
        tick();
        chk("short_done", 32'(done), 32'd1);
        chk("short_res", 32'(result), 32'h1);
        chk("short_nres", 32'(nresult), 32'h2);
        tick();

        // len=0 clamps to one step
        go(4'd0, 8'b00000011, 4'b0000, 4'b0001);
        chk_step("len0_s0", 2'b11, 1'b1);
        tick();
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_res", 32'(result), 32'h1);
        chk("len0_nres", 32'(nresult), 32'h0);
        tick();

        // len=9 clamps to four steps: q = 1,0,0,1
        go(4'd9, 8'b11100100, 4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk("len9_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("len9_done", 32'(done), 32'd1);
        chk("len9_res", 32'(result), 32'h9);
        chk("len9_nres", 32'(nresult), 32'h6);
        tick();

        // start held through RUN and DONE: no retrigger until back in IDLE
        len = 4'd1; op_seq = 8'h00; a_vec = 4'b0001; b_vec = 4'b0000;
        start = 1'b1;
        tick();
        chk_step("hold_run", 2'b00, 1'b1);
        a_vec = 4'b0000;
        tick();
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_res", 32'(result), 32'h1);
        tick();
        chk("hold_idle_busy", 32'(busy), 32'd0);
        chk("hold_idle_done", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        chk_step("hold_rerun", 2'b00, 1'b0);
        chk("hold_clr", 32'(result), 32'd0);
        tick();
        chk("hold2_done", 32'(done), 32'd1);
        chk("hold2_res", 32'(result), 32'h0);
        chk("hold2_nres", 32'(nresult), 32'h1);
        tick();

        // abort at step 2: q0=0, q1=1 kept, upper bits stay 0
        go(4'd4, 8'h00, 4'b0110, 4'b0000);
        tick();
        tick();
        chk_step("abort_s2", 2'b00, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_quiet("abort");
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res", 32'(result), 32'h2);
        chk("abort_nres", 32'(nresult), 32'h1);
        tick();
        chk("abort_nodone", 32'(done), 32'd0);

        // abort in IDLE has no effect; abort with start in IDLE lets start win
        abort = 1'b1;
        tick();
        chk("abort_idle", 32'(result), 32'h2);
        len = 4'd4; op_seq = 8'b11100100; a_vec = 4'b0101; b_vec = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_step("abst_s0", 2'b00, 1'b1);

        // reset mid-RUN
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("midrst");
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_res", 32'(result), 32'd0);
        chk("midrst_nres", 32'(nresult), 32'd0);
        tick();
        chk_quiet("midrst_idle");

`ifdef SELSEQ_PARITY_EN
        go(4'd4, 8'h00, 4'b0111, 4'b0000);
        tick(); tick(); tick(); tick();
        chk("par_res", 32'(result), 32'h7);
        chk("par_odd", 32'(parity), 32'd1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
